ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-port RAM arbiter and access sequencer sharing one byte-lane RAM between the pipeline's instruction-fetch port and its data-memory port. It sits between the Mips core and the Ram, in place of a purely combinational memory controller. It serialises requests, runs a multi-cycle command/wait/response sequence per access, and returns a one-cycle acknowledge that the core uses as its stall release. Data-memory requests have priority over fetch, and a bounded-starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 4 byte lanes.
- RAM_LAT, 1, cycles from the edge that samples ram_en to valid ram_rdata; legal range 1..4.
- STARVE_MAX, 4, maximum consecutive mem grants while if_req is pending; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch read request; held high with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DATA_W  fetched word; holds its value until the next fetch ack.
- mem_req  in  1  data request; held high with mem_rw, mem_addr, mem_wdata and mem_be stable until mem_ack.
- mem_rw  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data; lanes ordered {1h,1l,2h,2l} from MSB to LSB.
- mem_be  in  4  byte enables {1h,1l,2h,2l}.
- mem_ack  out  1  one-cycle completion pulse.
- mem_rdata  out  DATA_W  read data; valid with mem_ack.
- ram_en, ram_rw  out  1 each  RAM command strobe and direction.
- ram_addr  out  ADDR_W  RAM address.
- ram_be  out  4  RAM lane enables.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  0 = fetch, 1 = mem; identifies the current or last grant.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE, arbitration on each edge:
  - Only one requester high: grant it.
  - Both high: grant mem, unless streak == STARVE_MAX, in which case grant fetch.
  - On grant: latch owner, address, rw, be and wdata, then go to CMD.
  - Fetch accesses always use rw=0 and be=4'b1111.
- streak counter (4 bits):
  - Increments on a mem grant while if_req is high, saturating at STARVE_MAX.
  - Clears on any fetch grant, or on a mem grant with if_req low.
- Null access: a mem grant with mem_be == 4'b0000 issues no RAM command. It goes IDLE→RESP, mem_ack pulses, and mem_rdata is 0.
- CMD: ram_en=1 for exactly one cycle, with the latched fields on the ram_* outputs.
  - Write: go to RESP.
  - Read: if RAM_LAT == 1, capture ram_rdata at the edge ending CMD+1 cycle... see below.
- WAIT: a down-counter loaded with RAM_LAT-1 counts down. On the edge where ram_rdata is valid (RAM_LAT edges after the edge that sampled ram_en), capture it into the owner's rdata register and go to RESP. For RAM_LAT == 1 the WAIT phase lasts one cycle.
- RESP: the owner's ack is 1 for one cycle. req inputs are ignored in this state. Always return to IDLE.
- Read data for lanes with be=0 is passed through unmodified; masking is the core's job.
- ram_* outputs are zero in every state except CMD. All outputs are registered.

## Timing
- Let E0 be the IDLE edge that grants.
- CMD occupies the cycle after E0; the RAM samples at E1.
- Write: ack is high in the cycle after E1. Total occupancy is 3 cycles, IDLE included.
- Read: data is captured at edge E1+RAM_LAT; ack is high in the following cycle. Occupancy is RAM_LAT+3 cycles.
- A requester holding req high through the ack cycle is treated as a new request at the next IDLE edge.
- Reset (asynchronous, any state):
  - State goes to IDLE, streak=0, counters 0.
  - All outputs 0, including if_rdata, mem_rdata and owner.
  - An in-flight access is discarded with no ack. A RAM write already issued is not rolled back.
- Input changes while req is high and before ack are undefined behaviour. Bench assertions flag them.

## Test plan
- Fetch read, RAM_LAT=2, RAM word 0x8C010004 at address 0x10: if_req at E0 → ram_en high 1 cycle with ram_addr=0x10 and ram_be=1111; if_ack in the 4th cycle after E0 with if_rdata=0x8C010004; busy for 4 cycles.
- mem byte write, addr 0x22, be=0100, wdata=0x00AB0000: one CMD cycle with ram_rw=1 and ram_be=0100; mem_ack 2 cycles after grant; only RAM byte 0x22 changes to 0xAB.
- if_req and mem_req raised in the same cycle: mem is served first, and fetch is granted at the IDLE edge after mem_ack. owner sequence is 1 then 0.
- STARVE_MAX=2, mem_req held continuously with back-to-back reads, if_req held: grant order mem, mem, fetch, mem, mem, fetch.
- reset pulsed during WAIT of a mem read: no mem_ack, all outputs 0 immediately; the first request after reset is granted normally.
- mem read with be=0000: no ram_en pulse; mem_ack in the cycle after grant with mem_rdata=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Shares one single-port, byte-lane RAM between the instruction
//             fetch port and the data-memory port. Each access runs a
//             command / wait / response sequence and ends with a one-cycle
//             acknowledge that the core uses to release its stall.
//             The data port has priority. A starvation counter forces a fetch
//             grant after STARVE_MAX consecutive data grants that were made
//             while a fetch was pending.
//  Ports    : clock, reset (async, active-high)
//             if_req/if_addr -> if_ack/if_rdata        fetch read port
//             mem_req/rw/addr/wdata/be -> mem_ack/rdata data port
//             ram_en/rw/addr/be/wdata, ram_rdata        RAM command port
//             busy (state != IDLE), owner (0 fetch, 1 mem; last grant)
//  Revision : 1.0  initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // data-memory port
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_be,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    // RAM side
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    // status
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    // WAIT counts down from RAM_LAT-1 and captures when it reaches zero,
    // so it lasts exactly RAM_LAT cycles.
    localparam logic [1:0] c_WAIT_LOAD  = 2'(RAM_LAT - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_streak;
    logic [1:0] r_wait_cnt;

    logic w_grant_mem;
    logic w_grant_if;
    logic w_null_access;

    // Data port wins unless the fetch port has already been passed over
    // STARVE_MAX times in a row.
    assign w_grant_mem   = mem_req && !(if_req && (r_streak == c_STARVE_MAX));
    assign w_grant_if    = if_req && !w_grant_mem;
    assign w_null_access = (mem_be == 4'b0000);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_mem && w_null_access) begin
                    w_state_nxt = c_RESP;
                end else if (w_grant_mem || w_grant_if) begin
                    w_state_nxt = c_CMD;
                end
            end
            // ram_rw still holds the direction of the command being issued
            c_CMD:   w_state_nxt = ram_rw ? c_RESP : c_WAIT;
            c_WAIT:  w_state_nxt = (r_wait_cnt == 2'd0) ? c_RESP : c_WAIT;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_streak   <= 4'd0;
            r_wait_cnt <= 2'd0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            mem_ack    <= 1'b0;
            mem_rdata  <= '0;
            ram_en     <= 1'b0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_be     <= 4'b0000;
            ram_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt != c_IDLE);

            // RAM command fields and acks are single-cycle; zero by default
            ram_en    <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_be    <= 4'b0000;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_grant_mem) begin
                        owner <= 1'b1;
                        if (if_req) begin
                            if (r_streak != c_STARVE_MAX) begin
                                r_streak <= r_streak + 4'd1;
                            end
                        end else begin
                            r_streak <= 4'd0;
                        end
                        if (w_null_access) begin
                            // no lanes enabled: answer without touching RAM
                            mem_ack   <= 1'b1;
                            mem_rdata <= '0;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_rw    <= mem_rw;
                            ram_addr  <= mem_addr;
                            ram_be    <= mem_be;
                            ram_wdata <= mem_wdata;
                        end
                    end else if (w_grant_if) begin
                        owner     <= 1'b0;
                        r_streak  <= 4'd0;
                        ram_en    <= 1'b1;
                        ram_addr  <= if_addr;
                        ram_be    <= 4'b1111;
                    end
                end
                c_CMD: begin
                    if (ram_rw) begin
                        if (owner) begin
                            mem_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= c_WAIT_LOAD;
                    end
                end
                c_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        if (owner) begin
                            mem_rdata <= ram_rdata;
                            mem_ack   <= 1'b1;
                        end else begin
                            if_rdata <= ram_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                default: begin
                    // RESP: ack is already up for this cycle; requests ignored
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Purpose  : Directed self-checking bench for ram_port_arbiter with
//             RAM_LAT=2 and STARVE_MAX=2, driving a small byte-lane RAM model
//             (lane i of a word lives at byte address base+i).
//  Ports    : none (top-level bench)
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int c_LAT = 2;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    logic        owner;

    int checks;
    int failures;

    ram_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RAM_LAT    (c_LAT),
        .STARVE_MAX (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- RAM model: 256 bytes, RAM_LAT-stage read pipe -------
    logic [7:0]  ram_mem [0:255];
    logic [31:0] rd_pipe [0:1];
    logic        ram_init;
    logic [5:0]  w_base;

    assign w_base    = ram_addr[7:2];
    assign ram_rdata = rd_pipe[1];

    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i);
            ram_mem[8'h10] <= 8'h04;
            ram_mem[8'h11] <= 8'h00;
            ram_mem[8'h12] <= 8'h01;
            ram_mem[8'h13] <= 8'h8C;
            rd_pipe[0] <= 32'h0;
            rd_pipe[1] <= 32'h0;
        end else begin
            if (ram_en && ram_rw) begin
                if (ram_be[0]) ram_mem[{w_base, 2'd0}] <= ram_wdata[7:0];
                if (ram_be[1]) ram_mem[{w_base, 2'd1}] <= ram_wdata[15:8];
                if (ram_be[2]) ram_mem[{w_base, 2'd2}] <= ram_wdata[23:16];
                if (ram_be[3]) ram_mem[{w_base, 2'd3}] <= ram_wdata[31:24];
            end
            if (ram_en && !ram_rw) begin
                rd_pipe[0] <= {ram_mem[{w_base, 2'd3}], ram_mem[{w_base, 2'd2}],
                               ram_mem[{w_base, 2'd1}], ram_mem[{w_base, 2'd0}]};
            end else begin
                rd_pipe[0] <= 32'h0;
            end
            rd_pipe[1] <= rd_pipe[0];
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ram_en();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ram_en && n < 20);
        chkb("grant_timeout", ram_en, 1'b1);
    endtask

    task automatic wait_if_ack();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!if_ack && n < 20);
        chkb("if_ack_timeout", if_ack, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence -----------------------------------
    initial begin
        logic [5:0]  exp_order;
        logic [31:0] word20;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        ram_init  = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'b0000;

        tick();
        tick();
        // reset state
        chkb("rst_busy",  busy,  1'b0);
        chkb("rst_owner", owner, 1'b0);
        chkb("rst_ram_en", ram_en, 1'b0);
        chkw("rst_if_rdata", if_rdata, 32'h0);
        chkw("rst_mem_rdata", mem_rdata, 32'h0);
        reset    = 1'b0;
        ram_init = 1'b0;
        tick();

        // ---- 1: fetch read from 0x10, 4 busy cycles ----
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();                                           // E0
        chkb("f_ram_en", ram_en, 1'b1);
        chkw("f_ram_addr", ram_addr, 32'h10);
        chkw("f_ram_be", {28'h0, ram_be}, 32'hF);
        chkb("f_ram_rw", ram_rw, 1'b0);
        chkb("f_owner", owner, 1'b0);
        chkb("f_busy1", busy, 1'b1);
        tick();                                           // E1
        chkb("f_ram_en_off", ram_en, 1'b0);
        chkb("f_busy2", busy, 1'b1);
        tick();                                           // E2
        chkb("f_busy3", busy, 1'b1);
        chkb("f_early_ack", if_ack, 1'b0);
        tick();                                           // E3
        chkb("f_ack", if_ack, 1'b1);
        chkw("f_rdata", if_rdata, 32'h8C010004);
        chkb("f_busy4", busy, 1'b1);
        if_req = 1'b0;
        tick();
        chkb("f_ack_pulse", if_ack, 1'b0);
        chkb("f_idle", busy, 1'b0);
        chkw("f_rdata_hold", if_rdata, 32'h8C010004);

        // ---- 2: byte write of 0xAB to address 0x22 ----
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = 32'h22;
        mem_wdata = 32'h00AB0000;
        mem_be    = 4'b0100;
        tick();                                           // E0
        chkb("w_ram_en", ram_en, 1'b1);
        chkb("w_ram_rw", ram_rw, 1'b1);
        chkw("w_ram_be", {28'h0, ram_be}, 32'h4);
        chkw("w_ram_wdata", ram_wdata, 32'h00AB0000);
        chkb("w_owner", owner, 1'b1);
        tick();                                           // E1
        chkb("w_ack", mem_ack, 1'b1);
        chkb("w_ram_en_off", ram_en, 1'b0);
        chkb("w_ram_rw_off", ram_rw, 1'b0);
        mem_req = 1'b0;
        word20  = {ram_mem[8'h23], ram_mem[8'h22], ram_mem[8'h21], ram_mem[8'h20]};
        chkw("w_ram_word20", word20, 32'h23AB2120);
        tick();
        chkb("w_ack_pulse", mem_ack, 1'b0);
        chkb("w_idle", busy, 1'b0);

        // ---- 3: simultaneous requests, mem first then fetch ----
        if_req   = 1'b1;
        if_addr  = 32'h10;
        mem_req  = 1'b1;
        mem_rw   = 1'b0;
        mem_addr = 32'h20;
        mem_be   = 4'b1111;
        tick();                                           // E0
        chkb("s_owner_mem", owner, 1'b1);
        chkw("s_addr_mem", ram_addr, 32'h20);
        tick();
        tick();
        tick();                                           // E3
        chkb("s_mem_ack", mem_ack, 1'b1);
        chkw("s_mem_rdata", mem_rdata, 32'h23AB2120);
        chkb("s_no_if_ack", if_ack, 1'b0);
        mem_req = 1'b0;
        tick();                                           // RESP -> IDLE
        chkb("s_idle_gap", busy, 1'b0);
        tick();                                           // IDLE edge grants fetch
        chkb("s_owner_if", owner, 1'b0);
        chkb("s_if_ram_en", ram_en, 1'b1);
        chkw("s_addr_if", ram_addr, 32'h10);
        wait_if_ack();
        chkw("s_if_rdata", if_rdata, 32'h8C010004);
        if_req = 1'b0;
        tick();

        // ---- 4: starvation bound with STARVE_MAX=2 ----
        exp_order = 6'b011011;                            // g0..g5 = 1,1,0,1,1,0
        if_req    = 1'b1;
        if_addr   = 32'h10;
        mem_req   = 1'b1;
        mem_rw    = 1'b0;
        mem_addr  = 32'h20;
        mem_be    = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            wait_ram_en();
            chkb($sformatf("starve_grant%0d", g), owner, exp_order[g]);
        end
        wait_if_ack();
        if_req  = 1'b0;
        mem_req = 1'b0;
        tick();
        tick();
        chkb("starve_idle", busy, 1'b0);

        // ---- 5: reset in WAIT of a mem read ----
        mem_req  = 1'b1;
        mem_rw   = 1'b0;
        mem_addr = 32'h10;
        mem_be   = 4'b1111;
        tick();                                           // E0
        chkb("r_ram_en", ram_en, 1'b1);
        tick();                                           // E1 -> WAIT
        chkb("r_busy_wait", busy, 1'b1);
        reset   = 1'b1;
        mem_req = 1'b0;
        #1;
        chkb("r_busy0", busy, 1'b0);
        chkb("r_owner0", owner, 1'b0);
        chkb("r_mem_ack0", mem_ack, 1'b0);
        chkw("r_if_rdata0", if_rdata, 32'h0);
        chkw("r_mem_rdata0", mem_rdata, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chkb("r_no_ack1", mem_ack, 1'b0);
        tick();
        chkb("r_no_ack2", mem_ack, 1'b0);
        chkb("r_idle", busy, 1'b0);
        mem_req = 1'b1;
        tick();                                           // E0
        chkb("r_regrant", ram_en, 1'b1);
        chkw("r_regrant_addr", ram_addr, 32'h10);
        tick();
        tick();
        tick();                                           // E3
        chkb("r_ack", mem_ack, 1'b1);
        chkw("r_rdata", mem_rdata, 32'h8C010004);
        mem_req = 1'b0;
        tick();

        // ---- 6: null access (be=0000) ----
        mem_req  = 1'b1;
        mem_rw   = 1'b0;
        mem_addr = 32'h10;
        mem_be   = 4'b0000;
        tick();                                           // E0
        chkb("n_ack", mem_ack, 1'b1);
        chkw("n_rdata", mem_rdata, 32'h0);
        chkb("n_no_ram_en", ram_en, 1'b0);
        chkb("n_busy", busy, 1'b1);
        mem_req = 1'b0;
        tick();
        chkb("n_ack_pulse", mem_ack, 1'b0);
        chkb("n_no_ram_en2", ram_en, 1'b0);
        chkb("n_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
